// File: rtl/log_pkg.sv
// log_pkg
// Shared definitions for the log_ring event logger.
//   OP_RXA / OP_LOG : datapath opcodes that can trigger a log capture.
//   FLAG_W          : number of status flag bits at the top of an entry.
//   entry_w()       : total entry width for a given parameter set.
//   *_lsb()         : bit offset of each entry field, LSB first:
//                     ts | ndt | host data | flags
package log_pkg;

    localparam logic [1:0] OP_RXA = 2'b10;
    localparam logic [1:0] OP_LOG = 2'b11;

    localparam int FLAG_W = 4;

    function automatic int entry_w(input int data_size, input int tag_size, input int ts_size);
        return FLAG_W + data_size + (data_size + tag_size) + ts_size;
    endfunction

    // Timestamp occupies the least significant bits.
    function automatic int ts_lsb();
        return 0;
    endfunction

    function automatic int ndt_lsb(input int ts_size);
        return ts_size;
    endfunction

    function automatic int host_lsb(input int data_size, input int tag_size, input int ts_size);
        return ts_size + data_size + tag_size;
    endfunction

    function automatic int flag_lsb(input int data_size, input int tag_size, input int ts_size);
        return host_lsb(data_size, tag_size, ts_size) + data_size;
    endfunction

endpackage

// File: rtl/log_ring_mem.sv
// log_ring_mem
// Circular storage for the event log: entry array, write/read pointers,
// occupancy count and full/empty flags. The caller decides the policy;
// this block just does what wr_en / rd_adv say.
//
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   clear          : synchronous flush of pointers and count (contents kept)
//   wr_en, wr_data : store wr_data at the write pointer and advance it
//   rd_adv         : advance the read pointer (a pop, or dropping the oldest
//                    entry when the caller overwrites a full ring)
//   rd_data        : entry at the read pointer, 0 when empty (fall-through)
//   count          : entries held, 0..DEPTH
//   full, empty    : decoded from the registered count
//
// The caller must never assert wr_en on a full ring without rd_adv, and
// never rd_adv on an empty ring; count then stays within 0..DEPTH.
module log_ring_mem #(
    parameter int WIDTH = 92,
    parameter int DEPTH = 256,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_adv,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage has no reset; only the bookkeeping does.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural rollover.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // A simultaneous write and advance leaves the occupancy unchanged.
            unique case ({wr_en, rd_adv})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/log_ring.sv
// log_ring
// Event logger beside the packet datapath. On a LOG opcode, or an RXA whose
// tag did not match, it captures the status flags, host word, network
// data+tag and a free-running timestamp into a circular log. Entries drain
// through a valid/ready read port.
//
// Ports:
//   clk, reset               : clock, asynchronous active-low reset
//   opcode, tag_match        : datapath opcode and RXA tag compare result
//   parity_error_in, host_data_ready_in,
//   network_data_ready_in, network_ack_in : status flags stored per entry
//   host_data_in, ndt_in     : host word, network data+tag
//   wrap_en                  : 1 = overwrite oldest when full, 0 = drop new
//   clear                    : synchronous flush of log and lost counter
//   rd_ready / rd_valid / rd_data : read port, oldest entry first
//   log_item, log_strobe     : copy of the entry captured last cycle
//   count, full, empty       : occupancy status
//   overflow_count           : saturating count of entries lost
//
// Read handshake: rd_valid is high whenever the log holds an entry and
// rd_data then shows the oldest one; an entry is consumed on a rising edge
// where rd_valid and rd_ready are both high. rd_valid does not depend on
// rd_ready, and a write into an empty log is visible only from the next
// cycle.
module log_ring
    import log_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int TAG_SIZE  = 8,
    parameter int MEM_DEPTH = 256,
    parameter int TS_SIZE   = 16,
    parameter int OVF_SIZE  = 16,
    localparam int ENTRY_W  = entry_w(DATA_SIZE, TAG_SIZE, TS_SIZE),
    localparam int CNT_W    = $clog2(MEM_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    opcode,
    input  logic                          tag_match,
    input  logic                          parity_error_in,
    input  logic                          host_data_ready_in,
    input  logic                          network_data_ready_in,
    input  logic                          network_ack_in,
    input  logic [DATA_SIZE-1:0]          host_data_in,
    input  logic [DATA_SIZE+TAG_SIZE-1:0] ndt_in,
    input  logic                          wrap_en,
    input  logic                          clear,
    input  logic                          rd_ready,
    output logic                          rd_valid,
    output logic [ENTRY_W-1:0]            rd_data,
    output logic [ENTRY_W-1:0]            log_item,
    output logic                          log_strobe,
    output logic [CNT_W-1:0]              count,
    output logic                          full,
    output logic                          empty,
    output logic [OVF_SIZE-1:0]           overflow_count
);

    localparam int NDT_W    = DATA_SIZE + TAG_SIZE;
    localparam int TS_LSB   = ts_lsb();
    localparam int NDT_LSB  = ndt_lsb(TS_SIZE);
    localparam int HOST_LSB = host_lsb(DATA_SIZE, TAG_SIZE, TS_SIZE);
    localparam int FLAG_LSB = flag_lsb(DATA_SIZE, TAG_SIZE, TS_SIZE);

    logic [TS_SIZE-1:0] ts;
    logic [ENTRY_W-1:0] entry;
    logic               log_req;
    logic               pop;
    logic               lost;
    logic               accept;
    logic               mem_wr;
    logic               mem_adv;

    // Capture request straight from the shared datapath decode.
    assign log_req = (opcode == OP_LOG) | ((opcode == OP_RXA) & ~tag_match);

    always_comb begin
        entry = '0;
        entry[TS_LSB   +: TS_SIZE]   = ts;
        entry[NDT_LSB  +: NDT_W]     = ndt_in;
        entry[HOST_LSB +: DATA_SIZE] = host_data_in;
        entry[FLAG_LSB +: FLAG_W]    = {parity_error_in, host_data_ready_in,
                                        network_data_ready_in, network_ack_in};
    end

    assign rd_valid = ~empty;
    assign pop      = rd_valid & rd_ready;

    // Full with no pop loses an entry: the new one in drop mode, the oldest
    // one in overwrite mode. A same-cycle pop makes room, so nothing is lost.
    assign lost   = log_req & full & ~pop;
    assign accept = log_req & (~full | pop | wrap_en);

    // Clear wins over everything: the write and the pop are both discarded.
    assign mem_wr  = accept & ~clear;
    assign mem_adv = (pop | (lost & wrap_en)) & ~clear;

    log_ring_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .wr_en   (mem_wr),
        .wr_data (entry),
        .rd_adv  (mem_adv),
        .rd_data (rd_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Timestamp keeps running through clear so entries stay comparable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_SIZE'(1);
        end
    end

    // Lost-entry counter sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_count <= '0;
        end else if (clear) begin
            overflow_count <= '0;
        end else if (lost && (overflow_count != '1)) begin
            overflow_count <= overflow_count + OVF_SIZE'(1);
        end
    end

    // Every request is reported here, including ones that were dropped or
    // discarded by clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            log_item   <= '0;
            log_strobe <= 1'b0;
        end else begin
            log_strobe <= log_req;
            log_item   <= log_req ? entry : '0;
        end
    end

endmodule

// File: tb/tb_log_ring.sv
module tb_log_ring;

    localparam int DW       = 32;
    localparam int TW       = 8;
    localparam int DEPTH    = 4;
    localparam int TSW      = 8;
    localparam int OW       = 4;
    localparam int EW       = 4 + DW + (DW + TW) + TSW;
    localparam int HOST_LSB = TSW + DW + TW;
    localparam int OVF_MAX  = (1 << OW) - 1;

    localparam logic [1:0] OP_NOP0 = 2'b00;
    localparam logic [1:0] OP_NOP1 = 2'b01;
    localparam logic [1:0] OP_RXA  = 2'b10;
    localparam logic [1:0] OP_LOG  = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       opcode = '0;
    logic             tag_match = 1'b0;
    logic             parity_error_in = 1'b0;
    logic             host_data_ready_in = 1'b0;
    logic             network_data_ready_in = 1'b0;
    logic             network_ack_in = 1'b0;
    logic [DW-1:0]    host_data_in = '0;
    logic [DW+TW-1:0] ndt_in = '0;
    logic             wrap_en = 1'b0;
    logic             clear = 1'b0;
    logic             rd_ready = 1'b0;

    logic             rd_valid;
    logic [EW-1:0]    rd_data;
    logic [EW-1:0]    log_item;
    logic             log_strobe;
    logic [2:0]       count;
    logic             full;
    logic             empty;
    logic [OW-1:0]    overflow_count;

    log_ring #(
        .DATA_SIZE (DW),
        .TAG_SIZE  (TW),
        .MEM_DEPTH (DEPTH),
        .TS_SIZE   (TSW),
        .OVF_SIZE  (OW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .opcode                (opcode),
        .tag_match             (tag_match),
        .parity_error_in       (parity_error_in),
        .host_data_ready_in    (host_data_ready_in),
        .network_data_ready_in (network_data_ready_in),
        .network_ack_in        (network_ack_in),
        .host_data_in          (host_data_in),
        .ndt_in                (ndt_in),
        .wrap_en               (wrap_en),
        .clear                 (clear),
        .rd_ready              (rd_ready),
        .rd_valid              (rd_valid),
        .rd_data               (rd_data),
        .log_item              (log_item),
        .log_strobe            (log_strobe),
        .count                 (count),
        .full                  (full),
        .empty                 (empty),
        .overflow_count        (overflow_count)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 0;

    logic [EW-1:0] exp_item_q[$];  // expected log_item per request, in order
    logic [EW-1:0] exp_rd_q[$];    // expected rd_data per pop, in order
    logic [EW-1:0] m_q[$];         // reference: log contents, oldest first
    int            m_ovf;
    logic [TSW-1:0] m_ts;
    int            s_cnt;          // occupancy visible during the current cycle
    int            s_ovf;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: expected entry missing (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_q.delete();
        exp_item_q.delete();
        exp_rd_q.delete();
        m_ovf = 0;
        m_ts  = '0;
        s_cnt = 0;
        s_ovf = 0;
    endtask

    // Applies the currently driven inputs as one clock cycle of the log.
    task automatic model_apply();
        logic          req;
        logic [EW-1:0] e;
        bit            do_pop;
        int            sz;
        s_cnt = m_q.size();
        s_ovf = m_ovf;
        req = (opcode == OP_LOG) || (opcode == OP_RXA && !tag_match);
        e = {parity_error_in, host_data_ready_in, network_data_ready_in, network_ack_in,
             host_data_in, ndt_in, m_ts};
        if (req) exp_item_q.push_back(e);
        if (clear) begin
            m_q.delete();
            m_ovf = 0;
        end else begin
            sz = m_q.size();
            do_pop = (sz > 0) && rd_ready;
            if (do_pop) exp_rd_q.push_back(m_q.pop_front());
            if (req) begin
                if (sz < DEPTH || do_pop) begin
                    m_q.push_back(e);
                end else begin
                    if (wrap_en) begin
                        void'(m_q.pop_front());
                        m_q.push_back(e);
                    end
                    if (m_ovf < OVF_MAX) m_ovf++;
                end
            end
        end
        m_ts = m_ts + 1'b1;
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic [1:0] op, input logic tm, input logic [DW-1:0] hd,
                         input logic rdy, input logic clr, input logic wrap);
        @(posedge clk);
        #1;
        opcode                = op;
        tag_match             = tm;
        host_data_in          = hd;
        rd_ready              = rdy;
        clear                 = clr;
        wrap_en               = wrap;
        parity_error_in       = 1'($urandom_range(0, 1));
        host_data_ready_in    = 1'($urandom_range(0, 1));
        network_data_ready_in = 1'($urandom_range(0, 1));
        network_ack_in        = 1'($urandom_range(0, 1));
        ndt_in                = {8'($urandom), 32'($urandom)};
        model_apply();
    endtask

    task automatic idle(input logic rdy);
        cycle(OP_NOP0, 1'b0, '0, rdy, 1'b0, wrap_en);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        opcode   = OP_NOP0;
        clear    = 1'b0;
        rd_ready = 1'b0;
        model_apply();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"},    count, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_data"},  rd_data, 0);
        check({tag, "_strobe"},   log_strobe, 0);
        check({tag, "_item"},     log_item, 0);
        check({tag, "_ovf"},      overflow_count, 0);
        check({tag, "_empty"},    empty, 1);
        check({tag, "_full"},     full, 0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (reset && mon_en) begin
                check("count", count, s_cnt);
                check("ovf", overflow_count, s_ovf);
                check("full", full, s_cnt == DEPTH);
                check("empty", empty, s_cnt == 0);
                check("rd_valid", rd_valid, s_cnt != 0);
                if (s_cnt == 0) check("rd_data_empty", rd_data, 0);
                if (rd_valid && rd_ready && !clear) begin
                    if (exp_rd_q.size() == 0) fail_now("rd_pop");
                    else check("rd_data", rd_data, exp_rd_q.pop_front());
                end
                if (log_strobe) begin
                    if (exp_item_q.size() == 0) fail_now("log_strobe");
                    else check("log_item", log_item, exp_item_q.pop_front());
                end else begin
                    check("log_item_idle", log_item, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (t=%0t)", $time);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] host_f;
        logic [TSW-1:0] ts_f;

        #1;
        check_reset_outputs("reset");
        model_reset();
        mon_en = 1;
        release_reset();

        // Three LOG captures, no reads.
        cycle(OP_LOG, 1'b0, 32'hA, 1'b0, 1'b0, 1'b0);
        cycle(OP_LOG, 1'b0, 32'hB, 1'b0, 1'b0, 1'b0);
        cycle(OP_LOG, 1'b0, 32'hC, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        #1;
        host_f = rd_data[HOST_LSB +: DW];
        check("three_log_count", count, 3);
        check("three_log_head", host_f, 32'hA);

        // Only the RXA tag miss is logged.
        cycle(OP_RXA,  1'b1, 32'h1D, 1'b0, 1'b0, 1'b0);
        cycle(OP_RXA,  1'b0, 32'h2D, 1'b0, 1'b0, 1'b0);
        cycle(OP_NOP0, 1'b0, 32'h3D, 1'b0, 1'b0, 1'b0);
        cycle(OP_NOP1, 1'b0, 32'h4D, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        #1;
        check("rxa_miss_count", count, 4);

        // Drop mode: six writes into an empty log.
        cycle(OP_NOP0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) cycle(OP_LOG, 1'b0, DW'(i), 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        #1;
        check("drop_full", full, 1);
        check("drop_count", count, 4);
        check("drop_ovf", overflow_count, 2);
        for (int i = 0; i < 5; i++) idle(1'b1);
        #1;
        check("drop_drained", empty, 1);

        // Overwrite mode: six writes, oldest two replaced.
        cycle(OP_NOP0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 6; i++) cycle(OP_LOG, 1'b0, DW'(i), 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        #1;
        host_f = rd_data[HOST_LSB +: DW];
        check("wrap_count", count, 4);
        check("wrap_ovf", overflow_count, 2);
        check("wrap_head", host_f, 32'd3);
        for (int i = 0; i < 5; i++) idle(1'b1);
        #1;
        check("wrap_empty", empty, 1);
        check("wrap_rd_data_zero", rd_data, 0);

        // Full, write and pop in the same cycle, drop mode.
        for (int i = 0; i < 4; i++) cycle(OP_LOG, 1'b0, 32'h11 + DW'(i), 1'b0, 1'b0, 1'b0);
        cycle(OP_LOG, 1'b0, 32'h77, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        #1;
        host_f = rd_data[HOST_LSB +: DW];
        check("fullpop_count", count, 4);
        check("fullpop_ovf", overflow_count, 2);
        check("fullpop_head", host_f, 32'h12);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic w;
            w = ($urandom_range(0, 15) == 0) ? ~wrap_en : wrap_en;
            cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 31) == 0), w);
        end

        // Asynchronous reset in the middle of a burst.
        cycle(OP_LOG, 1'b0, 32'hE1, 1'b0, 1'b0, 1'b0);
        cycle(OP_LOG, 1'b0, 32'hE2, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        repeat (2) @(posedge clk);
        release_reset();
        for (int i = 0; i < 3; i++) idle(1'b0);
        cycle(OP_LOG, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        #1;
        ts_f = log_item[TSW-1:0];
        check("post_reset_strobe", log_strobe, 1);
        check("post_reset_ts", ts_f, 8'd4);

        // Clear with a simultaneous request, after building up losses.
        for (int i = 0; i < 6; i++) cycle(OP_LOG, 1'b0, DW'(i), 1'b0, 1'b0, 1'b0);
        cycle(OP_LOG, 1'b0, 32'hCC, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        #1;
        check("clear_count", count, 0);
        check("clear_ovf", overflow_count, 0);
        check("clear_strobe", log_strobe, 1);

        idle(1'b0);
        idle(1'b0);
        #1;
        check("item_q_drained", exp_item_q.size(), 0);
        check("rd_q_drained", exp_rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/log_ring.md
Name: log_ring

Overview:
- Parametrised successor to the single-port event logger.
- Captures status flags, host data and network data+tag into a circular log memory on LOG opcodes and on RXA tag misses.
- Each entry carries a free-running timestamp.
- Supports two selectable full-memory modes: stop or overwrite-oldest.
- Entries drain through a valid/ready read port to the debug/host readout path.
- Sits beside the packet datapath, sharing its opcode and tag_match signals.

Parameters:
- DATA_SIZE, 32, host data width.
- TAG_SIZE, 8, tag width; ndt_in is DATA_SIZE+TAG_SIZE wide.
- MEM_DEPTH, 256, number of log entries; power of two, at least 2.
- TS_SIZE, 16, timestamp counter width.
- OVF_SIZE, 16, width of the saturating lost-entry counter.
- Derived: ENTRY_W = 4+DATA_SIZE+(DATA_SIZE+TAG_SIZE)+TS_SIZE (92 at defaults); PTR_W = clog2(MEM_DEPTH); CNT_W = clog2(MEM_DEPTH+1).

Ports:
- clk  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  2  datapath opcode; RXA=2'b10, LOG=2'b11.
- tag_match  in  1  RXA tag compare result.
- parity_error_in, host_data_ready_in, network_data_ready_in, network_ack_in  in  1 each  status flags.
- host_data_in  in  DATA_SIZE  host word.
- ndt_in  in  DATA_SIZE+TAG_SIZE  network data+tag.
- wrap_en  in  1  1 = overwrite oldest when full; 0 = drop new entries when full.
- clear  in  1  synchronous flush.
- rd_ready  in  1  reader accepts the head entry.
- rd_valid  out  1  log not empty.
- rd_data  out  ENTRY_W  oldest entry.
- log_item  out  ENTRY_W  entry captured last cycle.
- log_strobe  out  1  log_item valid pulse.
- count  out  CNT_W  entries held.
- full, empty  out  1 each  status.
- overflow_count  out  OVF_SIZE  entries lost since reset or clear.

Behaviour:
- Entry layout, MSB to LSB: {parity_error_in, host_data_ready_in, network_data_ready_in, network_ack_in, host_data_in, ndt_in, ts}.
- log_req = (opcode==LOG) | (opcode==RXA & !tag_match). Evaluated every cycle, combinationally.
- ts: free-running counter, +1 every cycle, wraps modulo 2^TS_SIZE. reset sets it to 0; clear does not affect it. The stored ts is the value in the cycle the entry is captured.
- Reset (reset low, immediate): wr_ptr=0, rd_ptr=0, count=0, overflow_count=0, ts=0, log_item=0, log_strobe=0. Memory contents are not reset.
- pop = rd_valid & rd_ready. On pop, rd_ptr increments.
- rd_data = empty ? 0 : mem[rd_ptr]. This is a combinational read (first-word fall-through).
- Not full: a log_req writes mem[wr_ptr] and increments wr_ptr. count becomes count+1-pop.
- Full, wrap_en=0, no pop: the write is dropped and overflow_count increments.
- Full, wrap_en=1, no pop: the write overwrites mem[wr_ptr], the oldest entry. Both pointers advance and count stays at MEM_DEPTH. overflow_count increments.
- Full with pop in the same cycle, either mode: the write is accepted and count is unchanged. Nothing is lost and overflow_count does not move.
- Empty with log_req and rd_ready together: no pop occurs. The entry becomes visible the next cycle.
- Pointers wrap modulo MEM_DEPTH.
- overflow_count saturates at all-ones.
- log_item and log_strobe are registered with one-cycle latency. log_strobe=1 and log_item=entry after any log_req, including a dropped one. Otherwise both are 0.
- clear (synchronous) zeroes wr_ptr, rd_ptr, count and overflow_count. clear has priority over a same-cycle write or pop; that write is discarded and is not counted as lost. log_strobe still reports it.
- full = (count==MEM_DEPTH); empty = (count==0). Both are derived from registered count.
- wrap_en may change at any time and takes effect on the cycle it is sampled.

Decomposition:
- Shared package log_pkg: OP_RXA and OP_LOG constants, entry field offset/width functions of the parameters, and a function for ENTRY_W.
- One sub-module, log_ring_mem: parametrised storage array plus wr/rd pointers, count and full/empty.
- The top level keeps log_req decode, the timestamp, the overwrite/drop policy, the overflow counter and the log_item register.

Test Plan:
- Scenario parameters: MEM_DEPTH=4, TS_SIZE=8, OVF_SIZE=4.
- Reset, then 3 LOG cycles with host_data_in=0xA,0xB,0xC and rd_ready=0 -> count=3, rd_data host field=0xA; each log_strobe is one cycle after its request with matching log_item.
- opcode=RXA with tag_match=1, then opcode=RXA with tag_match=0, opcodes 00/01 -> only the tag miss is logged; count increments by exactly 1.
- wrap_en=0, write 6 entries with no reads -> full=1, count=4, overflow_count=2; drain returns entries 1-4 in order with ascending ts.
- wrap_en=1, write 6 entries (data 1..6) -> count=4, overflow_count=2; drain returns 3,4,5,6 and then empty=1, rd_data=0.
- Full, log_req and rd_ready in the same cycle, wrap_en=0 -> pop returns the oldest entry, the new entry is stored, count stays 4, overflow_count is unchanged.
- Assert reset mid-burst at a non-edge time -> all outputs go to 0 immediately; the first post-reset entry has ts equal to the cycles elapsed since release. Separately, clear with a simultaneous log_req -> count=0, overflow_count=0, log_strobe=1.
